// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Holds the FSM state encoding and the shift-register reset value.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Replicated across the full shift-register width by the consumer.
  localparam logic SH_RST_BIT = 1'b0;

endpackage

// File: rtl/seq_generator.sv
// Serial pattern transmitter: captures a PAT_W-bit pattern on start and shifts it out MSB first.
// Optional continuous repeat is enabled by defining SEQ_GEN_REPEAT_EN.
module seq_generator
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic             repeat_mode,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
);

  localparam int CNT_W = $clog2(PAT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAT_W - 1);
  localparam logic [PAT_W-1:0] SH_RST   = {PAT_W{SH_RST_BIT}};

  // Handshake: start is a request sampled only while idle (busy=0); while busy=1
  // it is dropped, not queued. x is meaningful only in cycles where x_valid=1.

  state_t           state_q, state_d;
  logic [PAT_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef SEQ_GEN_REPEAT_EN
  logic [PAT_W-1:0] pat_q, pat_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q <= SH_RST;
    end else begin
      pat_q <= pat_d;
    end
  end
`else
  logic unused_repeat_mode;
  assign unused_repeat_mode = repeat_mode;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sh_q    <= SH_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
`ifdef SEQ_GEN_REPEAT_EN
    pat_d   = pat_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sh_d    = pattern;
          cnt_d   = CNT_LAST;
          state_d = ST_SHIFT;
`ifdef SEQ_GEN_REPEAT_EN
          pat_d   = pattern;
`endif
        end
      end
      ST_SHIFT: begin
        sh_d  = {sh_q[PAT_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
`ifdef SEQ_GEN_REPEAT_EN
          // Reload from the captured copy so the next frame follows with no gap.
          if (repeat_mode) begin
            sh_d  = pat_q;
            cnt_d = CNT_LAST;
          end else begin
            state_d = ST_DONE;
          end
`else
          state_d = ST_DONE;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs: decoded from registered state only.
  always_comb begin
    x       = 1'b0;
    x_valid = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        x       = sh_q[PAT_W-1];
        x_valid = 1'b1;
        busy    = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        x       = 1'b0;
        x_valid = 1'b0;
      end
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_generator.sv
// Self-checking bench for seq_generator against a per-cycle expected-output queue model.
// Repeat scenarios are exercised when SEQ_GEN_REPEAT_EN is defined.
module tb_seq_generator;

  localparam int PAT_W = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic             repeat_mode = 1'b0;
  logic             x, x_valid, busy, done;
  seq_gen_pkg::state_t dbg_state;

  seq_generator #(.PAT_W(PAT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .pattern     (pattern),
    .repeat_mode (repeat_mode),
    .x           (x),
    .x_valid     (x_valid),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Each entry is the expected {x, x_valid, busy, done} for one future cycle.
  logic [3:0]       exp_q[$];
  logic [3:0]       cur_exp = 4'b0000;
  logic [PAT_W-1:0] model_pat = '0;
  int               n_checks = 0;
  int               n_errors = 0;
  int               cyc = 0;
  int               run_ones = 0;
  logic             z_seen = 1'b0;
  logic             prev_valid = 1'b0;
  int               rise_q[$];
  logic             bits_q[$];
  int               done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // A frame is PAT_W data cycles, one done cycle, then one idle cycle during
  // which a new start cannot be taken.
  task automatic push_frame(input logic [PAT_W-1:0] p);
    for (int i = PAT_W - 1; i >= 0; i--) exp_q.push_back({p[i], 3'b110});
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0000);
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      exp_q.delete();
      cur_exp = 4'b0000;
    end else if (exp_q.size() != 0) begin
`ifdef SEQ_GEN_REPEAT_EN
      if (exp_q.size() == 2 && repeat_mode) begin
        exp_q.delete();
        push_frame(model_pat);
      end
`endif
      cur_exp = exp_q.pop_front();
    end else if (start) begin
      model_pat = pattern;
      push_frame(pattern);
      cur_exp = exp_q.pop_front();
    end else begin
      cur_exp = 4'b0000;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check("outputs", {28'd0, x, x_valid, busy, done}, {28'd0, cur_exp});
    if (x_valid && x) run_ones++;
    else if (x_valid) run_ones = 0;
    if (run_ones >= 3) z_seen = 1'b1;
    if (x_valid && !prev_valid) rise_q.push_back(cyc);
    if (x_valid) bits_q.push_back(x);
    if (done) done_cnt++;
    prev_valid = x_valid;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PAT_W-1:0] pat_v;
    int               gap;

    // Reset held for 3 cycles, then idle for 5 cycles.
    steps(3);
    check("reset_state", {28'd0, x, x_valid, busy, done}, 32'd0);
    reset_n = 1'b1;
    steps(5);

    // Basic 111 frame with a one-cycle start pulse.
    run_ones = 0; z_seen = 1'b0; bits_q.delete(); done_cnt = 0;
    pattern = 3'b111; start = 1'b1;
    step();
    start = 1'b0;
    steps(PAT_W + 3);
    check("det_111_z", {31'd0, z_seen}, 32'd1);
    check("basic_valid_bits", bits_q.size(), PAT_W);
    check("basic_done_cnt", done_cnt, 1);

    // Bit order, pattern changed after capture.
    bits_q.delete();
    pattern = 3'b101; start = 1'b1;
    step();
    start = 1'b0; pattern = 3'b000;
    steps(PAT_W + 2);
    pat_v = '0;
    if (bits_q.size() == PAT_W)
      for (int i = 0; i < PAT_W; i++) pat_v = {pat_v[PAT_W-2:0], bits_q[i]};
    check("bit_order_101", {29'd0, pat_v}, 32'd5);

    // start held high through SHIFT and DONE.
    rise_q.delete(); done_cnt = 0;
    pattern = 3'($urandom_range(0, 7)); start = 1'b1;
    steps(2 * (PAT_W + 2) + 1);
    start = 1'b0;
    steps(PAT_W + 2);
    gap = (rise_q.size() >= 2) ? rise_q[1] - rise_q[0] : -1;
    check("restart_gap", gap, PAT_W + 2);
    check("held_start_done_cnt", done_cnt, 3);

    // Asynchronous reset after the second bit.
    done_cnt = 0;
    pattern = 3'b111; start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete(); cur_exp = 4'b0000;
    check("async_rst_valid", {31'd0, x_valid}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_x", {31'd0, x}, 32'd0);
    steps(2);
    @(negedge clk) reset_n = 1'b1;
    steps(3);
    check("async_rst_no_done", done_cnt, 0);
    bits_q.delete();
    pattern = 3'b011; start = 1'b1;
    step();
    start = 1'b0;
    steps(PAT_W + 2);
    check("post_reset_bits", bits_q.size(), PAT_W);
    check("post_reset_done", done_cnt, 1);

`ifdef SEQ_GEN_REPEAT_EN
    // Continuous repeat of 110, then drop repeat_mode.
    bits_q.delete(); done_cnt = 0;
    pattern = 3'b110; repeat_mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    steps(3 * PAT_W - 1);
    check("repeat_len", bits_q.size(), 3 * PAT_W);
    for (int i = 0; i < bits_q.size(); i++)
      check("repeat_bit", {31'd0, bits_q[i]}, {31'd0, (i % PAT_W) != (PAT_W - 1)});
    check("repeat_valid_high", {31'd0, x_valid}, 32'd1);
    check("repeat_no_done", done_cnt, 0);
    repeat_mode = 1'b0;
    steps(2 * PAT_W + 2);
    check("repeat_end_done", done_cnt, 1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      start       = ($urandom_range(0, 3) == 0);
      pattern     = PAT_W'($urandom);
      repeat_mode = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 99) == 0) begin
        #2 reset_n = 1'b0;
        #1;
        exp_q.delete(); cur_exp = 4'b0000;
        check("rand_async_rst", {28'd0, x, x_valid, busy, done}, 32'd0);
        step();
        @(negedge clk) reset_n = 1'b1;
      end else begin
        step();
      end
    end
    start = 1'b0; repeat_mode = 1'b0;
    steps(2 * PAT_W + 4);
    check("final_idle", {28'd0, x, x_valid, busy, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_generator.md
Name: seq_generator

Overview:
- Serial pattern transmitter: the source end of the serial-bit interface that our sequence detectors consume.
- On a start request it captures a PAT_W-bit pattern and drives it onto x, MSB first, one bit per clock, with a valid qualifier.
- Moore FSM: all outputs are functions of registered state only.
- Used to drive detector benches and on-chip serial test patterns. The default configuration emits 3'b111 for the "111" detector.

Parameters:
- PAT_W, 3, pattern length in bits; legal range is PAT_W >= 2.
- CNT_W, $clog2(PAT_W), width of the bit counter; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- pattern  input  PAT_W  bits to send; captured on the accepted start edge
- repeat_mode  input  1  continuous-repeat request; ignored unless SEQ_GEN_REPEAT_EN is defined
- x  output  1  serial data bit, MSB of the pattern first
- x_valid  output  1  high while x carries a pattern bit
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse after the last bit

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - reset_n is asynchronous and active-low. Assertion forces state IDLE immediately, independent of clk.
  - Reset values: x=0, x_valid=0, busy=0, done=0, shift register=0, counter=0, pattern copy=0.
- States:
  - IDLE: x=0, x_valid=0, busy=0, done=0.
  - SHIFT: x=sh[PAT_W-1], x_valid=1, busy=1, done=0.
  - DONE: x=0, x_valid=0, busy=1, done=1.
- IDLE:
  - start=1 at a clk edge: sh<=pattern, cnt<=PAT_W-1, state<=SHIFT.
  - start=0: remain in IDLE.
- SHIFT:
  - Each edge: sh<=sh<<1 (zero fill) and cnt<=cnt-1.
  - When cnt==0 at the edge, go to DONE.
- DONE: lasts exactly one cycle, then IDLE.
- Latency:
  - start accepted at edge k gives bit pattern[PAT_W-1] in the cycle after edge k.
  - Bit pattern[PAT_W-1-i] is on x in the cycle after edge k+i, for i = 0..PAT_W-1.
  - done is high in the cycle after edge k+PAT_W.
  - Earliest next accept is edge k+PAT_W+2.
- start in SHIFT or DONE: ignored, never queued.
- Changes to pattern after capture: no effect on the frame in progress.
- x_valid: never high outside SHIFT; exactly PAT_W valid cycles per frame.
- Reset mid-frame: frame is aborted, outputs go to reset values immediately, no done pulse.
- Illegal or unused state encodings: next state IDLE.

Optional Feature:
- Macro: SEQ_GEN_REPEAT_EN.
- Defined:
  - Accepting start also stores pattern into a pattern copy register (pat_q).
  - In SHIFT with cnt==0 and repeat_mode=1 at the edge: sh<=pat_q, cnt<=PAT_W-1, stay in SHIFT. x_valid stays high with no gap and no done pulse.
  - When repeat_mode=0 at the last-bit edge, the FSM moves to DONE normally.
- Not defined: the repeat_mode port exists but is unused, there is no pat_q register, and every frame is single-shot.

Decomposition:
- Package seq_gen_pkg holds:
  - the state typedef, 2-bit, with IDLE=0, SHIFT=1, DONE=2;
  - a localparam for the reset value of the shift register.
- No sub-module is required. The shift register and counter stay inline, because splitting out a PISO would add more ports than it saves.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles, then release with start=0 -> x=0, x_valid=0, busy=0, done=0 for 5 cycles.
- Basic frame: pattern=3'b111, one-cycle start pulse -> x=1,1,1 with x_valid=1 for exactly 3 cycles, then done=1 for 1 cycle, then IDLE. A connected "111" detector raises z.
- Bit order: PAT_W=3, pattern=3'b101 -> x=1,0,1. Change pattern to 3'b000 during SHIFT -> output stays 1,0,1.
- start ignored: assert start continuously in SHIFT and DONE -> no restart. The second frame's first valid bit appears exactly PAT_W+2 cycles after the first.
- Async reset mid-frame: drop reset_n between clock edges after the second bit -> x_valid and busy fall immediately, no done pulse. Restart after release works normally.
- With SEQ_GEN_REPEAT_EN, pattern=3'b110, repeat_mode=1 -> x=1,1,0,1,1,0,... with x_valid continuously high. Drop repeat_mode -> the current frame completes, then done pulses once.
